// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC and issues instruction reads to the RAM2 controller.
// It presents one registered instruction downstream over a valid/ready handshake.
module inst_fetch #(
    parameter int unsigned     ADDR_W   = 18,
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              need_to_work_if,
    output logic [ADDR_W-1:0] mem_addr_if,
    input  logic [15:0]       if_result,
    input  logic              if_work_done,
    input  logic              redirect_en,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [15:0]       inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic [15:0]       fetch_wait_cnt,
    output logic [15:0]       inst_count
);

    typedef enum logic [0:0] {StFetch, StHold} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     inst_q, inst_d;
    logic [PC_W-1:0] inst_pc_q, inst_pc_d;
    logic            valid_q, valid_d;
    logic [15:0]     wait_cnt_q, wait_cnt_d;
    logic [15:0]     inst_cnt_q, inst_cnt_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        valid_d    = valid_q;
        wait_cnt_d = wait_cnt_q;
        inst_cnt_d = inst_cnt_q;

        // A redirect wins over a completing read and over a downstream accept.
        if (redirect_en) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            state_d = StFetch;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (if_work_done) begin
                        inst_d    = if_result;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_q + PC_W'(1);
                        state_d   = StHold;
                    end else if (wait_cnt_q != 16'hffff) begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                end
                StHold: begin
                    if (inst_ready) begin
                        inst_cnt_d = inst_cnt_q + 16'd1;
                        valid_d    = 1'b0;
                        state_d    = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            inst_q     <= 16'h0000;
            inst_pc_q  <= '0;
            valid_q    <= 1'b0;
            wait_cnt_q <= 16'h0000;
            inst_cnt_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            valid_q    <= valid_d;
            wait_cnt_q <= wait_cnt_d;
            inst_cnt_q <= inst_cnt_d;
        end
    end

    // The PC only moves on done/redirect/reset, so the address is stable for a whole transaction.
    assign need_to_work_if = (state_q == StFetch);
    assign mem_addr_if     = {{(ADDR_W - PC_W){1'b0}}, pc_q};
    assign inst_valid      = valid_q;
    assign inst            = inst_q;
    assign inst_pc         = inst_pc_q;
    assign fetch_wait_cnt  = wait_cnt_q;
    assign inst_count      = inst_cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a latency-programmable controller stub feeds the DUT and a queue of
// expected {pc, word} pairs is checked as instructions appear downstream.
module tb_inst_fetch;

    localparam int ADDR_W = 18;
    localparam int PC_W   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              need_to_work_if;
    logic [ADDR_W-1:0] mem_addr_if;
    logic [15:0]       if_result;
    logic              if_work_done;
    logic              redirect_en;
    logic [PC_W-1:0]   redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [15:0]       inst;
    logic [PC_W-1:0]   inst_pc;
    logic [15:0]       fetch_wait_cnt;
    logic [15:0]       inst_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb[$];  // {pc, word}
    logic [31:0] exp_e;

    // Controller stub: done after stub_lat waiting cycles on an unchanged request.
    int   stub_lat = 0;
    logic stub_en  = 1'b0;
    int   req_cnt  = 0;

    function automatic logic [15:0] word_of(input logic [15:0] a);
        return 16'h4A01 ^ {a[7:0], a[15:8]};
    endfunction

    assign if_work_done = stub_en && need_to_work_if && (req_cnt >= stub_lat);
    assign if_result    = word_of(mem_addr_if[15:0]);

    always @(posedge clk) begin
        if (rst || !need_to_work_if || if_work_done || redirect_en) req_cnt <= 0;
        else req_cnt <= req_cnt + 1;
    end

    always #5 clk = ~clk;

    inst_fetch #(
        .ADDR_W  (ADDR_W),
        .PC_W    (PC_W),
        .RESET_PC(16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .need_to_work_if(need_to_work_if),
        .mem_addr_if    (mem_addr_if),
        .if_result      (if_result),
        .if_work_done   (if_work_done),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_wait_cnt (fetch_wait_cnt),
        .inst_count     (inst_count)
    );

    // Leaves rst asserted across one edge, releases at a negedge; FETCH at pc 0 follows.
    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        stub_en     = 1'b0;
        stub_lat    = 0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst         = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        stub_en     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || inst !== 16'h0000 || inst_pc !== 16'h0000 ||
            fetch_wait_cnt !== 16'h0000 || inst_count !== 16'h0000 ||
            mem_addr_if !== 18'h00000 || need_to_work_if !== 1'b1) begin
            $display("FAIL reset_state: valid=%b inst=%h pc=%h wait=%h cnt=%h addr=%h need=%b",
                     inst_valid, inst, inst_pc, fetch_wait_cnt, inst_count, mem_addr_if,
                     need_to_work_if);
            errors++;
        end
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        stub_en  = 1'b1;
        stub_lat = 3;
        sb.push_back({16'h0000, word_of(16'h0000)});
        repeat (3) @(negedge clk);
        checks++;
        if (if_work_done !== 1'b1 || fetch_wait_cnt !== 16'd3 || mem_addr_if !== 18'h00000 ||
            need_to_work_if !== 1'b1) begin
            $display("FAIL first_fetch_wait: done=%b wait=%0d addr=%h need=%b (want 1,3,0,1)",
                     if_work_done, fetch_wait_cnt, mem_addr_if, need_to_work_if);
            errors++;
        end
        @(negedge clk);
        exp_e = sb.pop_front();
        checks++;
        if (inst_valid !== 1'b1 || inst !== exp_e[15:0] || inst_pc !== exp_e[31:16] ||
            need_to_work_if !== 1'b0) begin
            $display("FAIL first_fetch_data: valid=%b inst=%h pc=%h need=%b want inst=%h pc=%h",
                     inst_valid, inst, inst_pc, need_to_work_if, exp_e[15:0], exp_e[31:16]);
            errors++;
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (inst_valid !== 1'b1 || inst !== exp_e[15:0] || inst_pc !== exp_e[31:16] ||
                need_to_work_if !== 1'b0) begin
                $display("FAIL stall_hold[%0d]: valid=%b inst=%h pc=%h need=%b", i, inst_valid,
                         inst, inst_pc, need_to_work_if);
                errors++;
            end
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        checks++;
        if (inst_count !== 16'd1 || mem_addr_if !== 18'h00001 || need_to_work_if !== 1'b1 ||
            inst_valid !== 1'b0) begin
            $display("FAIL stall_accept: cnt=%0d addr=%h need=%b valid=%b (want 1,00001,1,0)",
                     inst_count, mem_addr_if, need_to_work_if, inst_valid);
            errors++;
        end
    endtask

    task automatic test_stream();
        int got = 0;
        int last_cyc = -1;
        do_reset();
        stub_en    = 1'b1;
        stub_lat   = 0;
        inst_ready = 1'b1;
        for (int p = 0; p < 4; p++) sb.push_back({16'(p), word_of(16'(p))});
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            if (inst_valid) begin
                exp_e = sb.pop_front();
                checks++;
                if (inst_pc !== exp_e[31:16] || inst !== exp_e[15:0] ||
                    (last_cyc >= 0 && cyc - last_cyc != 2)) begin
                    $display("FAIL stream[%0d]: pc=%h inst=%h gap=%0d want pc=%h inst=%h gap=2",
                             got, inst_pc, inst, cyc - last_cyc, exp_e[31:16], exp_e[15:0]);
                    errors++;
                end
                last_cyc = cyc;
                got++;
            end
            @(negedge clk);
        end
        inst_ready = 1'b0;
        stub_en    = 1'b0;
        checks++;
        if (got != 4 || inst_count !== 16'd4) begin
            $display("FAIL stream_count: seen=%0d inst_count=%0d (want 4,4)", got, inst_count);
            errors++;
        end
    endtask

    task automatic test_redirect_hold();
        do_reset();
        redirect_en = 1'b1;
        redirect_pc = 16'h0010;
        @(negedge clk);
        redirect_en = 1'b0;
        stub_en     = 1'b1;
        stub_lat    = 0;
        @(negedge clk);
        stub_en = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 16'h0010 || inst !== word_of(16'h0010)) begin
            $display("FAIL redir_hold_setup: valid=%b pc=%h inst=%h (want 1,0010,%h)",
                     inst_valid, inst_pc, inst, word_of(16'h0010));
            errors++;
        end
        inst_ready  = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 16'h0200;
        @(negedge clk);
        inst_ready  = 1'b0;
        redirect_en = 1'b0;
        checks++;
        if (inst_count !== 16'd0 || inst_valid !== 1'b0 || mem_addr_if !== 18'h00200 ||
            need_to_work_if !== 1'b1) begin
            $display("FAIL redir_hold: cnt=%0d valid=%b addr=%h need=%b (want 0,0,00200,1)",
                     inst_count, inst_valid, mem_addr_if, need_to_work_if);
            errors++;
        end
    endtask

    task automatic test_redirect_fetch();
        do_reset();
        redirect_en = 1'b1;
        redirect_pc = 16'h0005;
        @(negedge clk);
        stub_en     = 1'b1;
        stub_lat    = 0;
        redirect_pc = 16'h0040;
        @(negedge clk);
        stub_en     = 1'b0;
        redirect_en = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || mem_addr_if !== 18'h00040 || inst !== 16'h0000 ||
            inst_pc !== 16'h0000 || need_to_work_if !== 1'b1) begin
            $display("FAIL redir_fetch: valid=%b addr=%h inst=%h pc=%h need=%b (want 0,00040,0,0,1)",
                     inst_valid, mem_addr_if, inst, inst_pc, need_to_work_if);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0) begin
            $display("FAIL redir_fetch_stay: valid=%b (want 0)", inst_valid);
            errors++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_en = 1'b1;
        redirect_pc = 16'hffff;
        @(negedge clk);
        redirect_en = 1'b0;
        stub_en     = 1'b1;
        stub_lat    = 0;
        sb.push_back({16'hffff, word_of(16'hffff)});
        @(negedge clk);
        stub_en = 1'b0;
        exp_e   = sb.pop_front();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== exp_e[31:16] || inst !== exp_e[15:0]) begin
            $display("FAIL wrap_fetch: valid=%b pc=%h inst=%h want pc=%h inst=%h",
                     inst_valid, inst_pc, inst, exp_e[31:16], exp_e[15:0]);
            errors++;
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        checks++;
        if (mem_addr_if !== 18'h00000 || need_to_work_if !== 1'b1 || inst_count !== 16'd1) begin
            $display("FAIL wrap_next: addr=%h need=%b cnt=%0d (want 00000,1,1)",
                     mem_addr_if, need_to_work_if, inst_count);
            errors++;
        end
    endtask

    task automatic test_wait_saturate();
        do_reset();
        repeat (65534) @(negedge clk);
        checks++;
        if (fetch_wait_cnt !== 16'hfffe) begin
            $display("FAIL wait_pre_sat: cnt=%h (want fffe)", fetch_wait_cnt);
            errors++;
        end
        repeat (70000 - 65534) @(negedge clk);
        checks++;
        if (fetch_wait_cnt !== 16'hffff || need_to_work_if !== 1'b1) begin
            $display("FAIL wait_sat: cnt=%h need=%b (want ffff,1)", fetch_wait_cnt,
                     need_to_work_if);
            errors++;
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        stub_en    = 1'b1;
        stub_lat   = 0;
        inst_ready = 1'b1;
        repeat (2) @(negedge clk);
        inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        stub_en = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst_count !== 16'd1 || inst_pc !== 16'h0001) begin
            $display("FAIL midhold_setup: valid=%b cnt=%0d pc=%h (want 1,1,0001)",
                     inst_valid, inst_count, inst_pc);
            errors++;
        end
        rst        = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        inst_ready = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || inst !== 16'h0000 || inst_pc !== 16'h0000 ||
            fetch_wait_cnt !== 16'h0000 || inst_count !== 16'h0000 ||
            mem_addr_if !== 18'h00000 || need_to_work_if !== 1'b1) begin
            $display("FAIL midhold_reset: valid=%b inst=%h pc=%h wait=%h cnt=%h addr=%h need=%b",
                     inst_valid, inst, inst_pc, fetch_wait_cnt, inst_count, mem_addr_if,
                     need_to_work_if);
            errors++;
        end
    endtask

    initial begin
        rst         = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        test_reset();
        test_first_fetch();
        test_stall();
        test_stream();
        test_redirect_hold();
        test_redirect_fetch();
        test_wrap();
        test_wait_saturate();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the RAM2 controller.
- Owns the program counter and drives the controller's instruction-side request (need_to_work_if, mem_addr_if).
- Consumes the controller's if_result / if_work_done_out and presents one registered instruction to the IF/ID boundary through a valid/ready handshake.
- Handles branch/jump redirects and keeps fetch-performance counters.

Parameters:
- ADDR_W, 18, width of the RAM2 address bus (mem_addr_if).
- PC_W, 16, program-counter width; the upper ADDR_W-PC_W address bits are driven 0.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- need_to_work_if  out  1  instruction-read request to the RAM2 controller.
- mem_addr_if  out  ADDR_W  instruction address: {zeros, pc}.
- if_result  in  16  instruction word returned by the controller.
- if_work_done  in  1  controller done flag; already qualified by the controller against the current mem_addr_if.
- redirect_en  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  PC_W  redirect target.
- inst_valid  out  1  inst/inst_pc hold a valid instruction.
- inst_ready  in  1  downstream accepts the instruction this cycle.
- inst  out  16  fetched instruction.
- inst_pc  out  PC_W  address of inst.
- fetch_wait_cnt  out  16  saturating count of cycles spent in FETCH with if_work_done=0.
- inst_count  out  16  wrapping count of instructions accepted downstream.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC, state=FETCH, inst_valid=0, inst=16'h0000, inst_pc=0, fetch_wait_cnt=0, inst_count=0.
  - rst overrides every other input, including during an outstanding fetch.
- Outputs:
  - need_to_work_if is 1 in FETCH, 0 in HOLD.
  - mem_addr_if = {(ADDR_W-PC_W)'b0, pc} combinationally in both states.
- States: FETCH, HOLD. Each cycle is evaluated in the priority order below.
- Redirect (highest after rst):
  - pc<=redirect_pc, inst_valid<=0, state<=FETCH.
  - Any if_work_done in the same cycle is discarded and nothing is latched.
  - A held instruction is dropped even if inst_ready=1: no acceptance, inst_count unchanged.
- FETCH with if_work_done=1:
  - inst<=if_result, inst_pc<=pc, inst_valid<=1, pc<=pc+1 (wraps ffff->0000), state<=HOLD.
  - Latency from request to inst_valid is controller latency plus 1 cycle (registered output).
- FETCH with if_work_done=0:
  - Stay in FETCH; fetch_wait_cnt increments, saturating at 16'hffff.
  - The controller may be serving the exe side first; the fetch stage waits indefinitely with no timeout.
- HOLD with inst_ready=1:
  - Instruction accepted; inst_count<=inst_count+1 (wraps).
  - inst_valid<=0, state<=FETCH, with the new pc presented in the next cycle.
- HOLD with inst_ready=0: hold inst/inst_pc/inst_valid stable and keep need_to_work_if low.
- inst_ready while inst_valid=0 is ignored.
- Throughput: at most one instruction per 2 cycles beyond controller latency. No skid buffer.
- Redirect to the address of the last completed read: the controller may report done in the first FETCH cycle; that word is latched normally.
- pc never changes in FETCH except on done, redirect or rst, so mem_addr_if is stable throughout a controller transaction.

Test Plan:
1. Reset release, controller stub asserts if_work_done 3 cycles after request with if_result=16'h4A01 at pc 0 -> mem_addr_if=18'h00000, need_to_work_if=1; fetch_wait_cnt=3; next cycle inst_valid=1, inst=16'h4A01, inst_pc=0, need_to_work_if=0.
2. Same start, inst_ready held 0 for 5 cycles then 1 -> inst/inst_pc stable for 5 cycles; after accept inst_count=1, mem_addr_if=18'h00001, need_to_work_if=1.
3. Stream of 4 instructions with immediate done and inst_ready=1 -> inst_pc sequence 0,1,2,3 on alternate cycles, inst_count=4.
4. HOLD with inst_pc=0x0010, inst_ready=1 and redirect_en=1, redirect_pc=0x0200 in the same cycle -> inst_count unchanged, inst_valid=0, next mem_addr_if=18'h00200.
5. FETCH at pc 0x0005 with if_work_done=1 and redirect_en=1, redirect_pc=0x0040 -> nothing latched; pc=0x0040; inst_valid stays 0.
6. pc=0xFFFF fetched and accepted -> inst_pc=0xFFFF, next mem_addr_if=18'h00000. Separately, 70000 cycles without done -> fetch_wait_cnt=16'hffff. rst pulse mid-HOLD -> all outputs return to reset values on the next edge.
